subband_synth_combiner: RTL and testbench

//  Synthesis-side partner of the 16-channel analysis filterbank: takes one frame of channel outputs per

---
 rtl/subband_synth_combiner.sv | 150 +++++++++++++++
 tb/tb_subband_synth_combiner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/subband_synth_combiner.sv
// Synthesis combiner: per-channel gain and sum of one filterbank frame into an sfix13_En12 sample,
// using a single serial MAC stepped across the channels, with a valid/ready output port.
module subband_synth_combiner #(
  parameter int NUM_CH = 16,
  parameter int IN_W   = 33,
  parameter int GAIN_W = 16,
  parameter int OUT_W  = 13,
  parameter int ACC_W  = 53
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0][IN_W-1:0]  ch_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         gain_we,
  input  logic [3:0]                   gain_addr,
  input  logic [GAIN_W-1:0]            gain_data,
  output logic                         gain_err,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   drop_cnt
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int PROD_W    = IN_W + GAIN_W;
  localparam int PROD_FRAC = (IN_W - 1) + (GAIN_W - 2);
  localparam int FRAC_DROP = PROD_FRAC - (OUT_W - 1);
  localparam int R_W       = ACC_W - FRAC_DROP;
  localparam logic [CH_W-1:0]        LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [GAIN_W-1:0]      UNITY    = GAIN_W'(1 << (GAIN_W - 2));
  localparam logic signed [R_W-1:0]  OUT_MAX  = R_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [R_W-1:0]  OUT_MIN  = R_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, HOLD} state_t;

  state_t state, state_nxt;

  logic signed [IN_W-1:0]   frame [NUM_CH];
  logic signed [GAIN_W-1:0] gain  [NUM_CH];
  logic signed [ACC_W-1:0]  acc;
  logic [CH_W-1:0]          ch;
  logic signed [IN_W-1:0]   x_sel;
  logic signed [GAIN_W-1:0] g_sel;
  logic signed [PROD_W-1:0] prod;
  logic                     addr_ok;
  logic [OUT_W:0]           rounded;

  // Round half up from the product's En46 grid down to En12.
  function automatic logic signed [R_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] biased;
    biased = a + (ACC_W'(1) << (FRAC_DROP - 1));
    return R_W'(biased >>> FRAC_DROP);
  endfunction

  // Clamp to the output range; MSB of the result flags that clamping happened.
  function automatic logic [OUT_W:0] saturate(input logic signed [R_W-1:0] r);
    if (r > OUT_MAX)
      return {1'b1, OUT_MAX[OUT_W-1:0]};
    else if (r < OUT_MIN)
      return {1'b1, OUT_MIN[OUT_W-1:0]};
    else
      return {1'b0, r[OUT_W-1:0]};
  endfunction

  assign in_ready = (state == IDLE);
  assign addr_ok  = (32'(gain_addr) < 32'(NUM_CH));
  assign x_sel    = frame[ch];
  assign g_sel    = gain[ch];
  assign prod     = x_sel * g_sel;
  assign rounded  = saturate(round_half_up(acc));

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ACCUM;
      ACCUM:   if (ch == LAST_CH) state_nxt = ROUND;
      ROUND:   state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame capture: loaded only on an accepted frame, so no reset is needed.
  always_ff @(posedge clock) begin
    if (state == IDLE && in_valid) begin
      for (int i = 0; i < NUM_CH; i++)
        frame[i] <= ch_in[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc       <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      gain_err  <= 1'b0;
      drop_cnt  <= '0;
      for (int i = 0; i < NUM_CH; i++)
        gain[i] <= UNITY;
    end else begin
      gain_err <= 1'b0;
      if (gain_we) begin
        if (state == IDLE && addr_ok)
          gain[gain_addr] <= gain_data;
        else
          gain_err <= 1'b1;
      end

      if (in_valid && state != IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= '0;
            ch  <= '0;
          end
        end
        // ACCUM -> ROUND: one channel product per clock, sign-extended into the accumulator.
        ACCUM: begin
          acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
          ch  <= ch + CH_W'(1);
        end
        // ROUND -> HOLD: result registered and held until accepted.
        ROUND: begin
          out_sat   <= rounded[OUT_W];
          out_data  <= rounded[OUT_W-1:0];
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subband_synth_combiner.sv
// Directed bench for subband_synth_combiner: table of single-frame vectors plus hand-written
// sequences for capture-cycle gain writes, backpressure/drops and mid-frame reset.
module tb_subband_synth_combiner;

  logic               clock;
  logic               reset;
  logic [15:0][32:0]  ch_in;
  logic               in_valid;
  logic               in_ready;
  logic               gain_we;
  logic [3:0]         gain_addr;
  logic [15:0]        gain_data;
  logic               gain_err;
  logic [12:0]        out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         drop_cnt;

  int pass_cnt = 0;
  int total    = 0;

  subband_synth_combiner dut (
    .clock(clock), .reset(reset), .ch_in(ch_in), .in_valid(in_valid), .in_ready(in_ready),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data), .gain_err(gain_err),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  typedef struct {
    logic        all;
    int          ch;
    longint      x;
    logic [15:0] g;
    logic [12:0] exp_d;
    logic        exp_s;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic write_gain(input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    gain_we = 1'b1; gain_addr = a; gain_data = d;
    @(posedge clock); #1;
    gain_we = 1'b0;
    check("gain_err_idle_write", 64'(gain_err), 64'd0);
  endtask

  task automatic junk_frame();
    for (int i = 0; i < 16; i++) ch_in[i] = 33'h0_5A5A_5A5A ^ 33'(i);
  endtask

  task automatic run_frame(input string nm, input logic [15:0][32:0] fr,
                           input logic cap_we, input logic [15:0] cap_g,
                           input logic [12:0] ed, input logic es);
    int lat;
    @(negedge clock);
    ch_in = fr; in_valid = 1'b1;
    gain_we = cap_we; gain_addr = 4'd0; gain_data = cap_g;
    @(posedge clock); #1;
    in_valid = 1'b0; gain_we = 1'b0;
    junk_frame();
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'd17);
    check({nm, "_data"}, 64'(out_data), 64'(ed));
    check({nm, "_sat"}, 64'(out_sat), 64'(es));
    check({nm, "_in_ready_hold"}, 64'(in_ready), 64'd0);
  endtask

  task automatic accept(input string nm);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({nm, "_valid_clr"}, 64'(out_valid), 64'd0);
    check({nm, "_in_ready_idle"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [15:0][32:0] single(input int c, input longint x);
    logic [15:0][32:0] f;
    f = '0;
    f[c] = 33'(x);
    return f;
  endfunction

  vec_t vecs [9];
  logic [15:0][32:0] fr;
  int unstable;
  logic err_at, err_after;

  initial begin
    vecs[0] = '{1'b0, 0, 64'sd1 <<< 30, 16'h4000, 13'd1024, 1'b0};
    vecs[1] = '{1'b0, 3, 64'sd1 <<< 31, 16'h2000, 13'd1024, 1'b0};
    vecs[2] = '{1'b0, 0, 64'sd1 <<< 19, 16'h4000, 13'd1, 1'b0};
    vecs[3] = '{1'b0, 0, -(64'sd1 <<< 19), 16'h4000, 13'd0, 1'b0};
    vecs[4] = '{1'b0, 0, -(64'sd1 <<< 20), 16'h4000, 13'h1FFF, 1'b0};
    vecs[5] = '{1'b1, 0, 64'sd1 <<< 31, 16'h4000, 13'h0FFF, 1'b1};
    vecs[6] = '{1'b1, 0, -(64'sd1 <<< 31), 16'h4000, 13'h1000, 1'b1};
    vecs[7] = '{1'b0, 5, -(64'sd1 <<< 31), 16'h8000, 13'h0FFF, 1'b1};
    vecs[8] = '{1'b0, 2, 64'sd3 <<< 28, 16'h6000, 13'd1152, 1'b0};

    reset = 1'b0; in_valid = 1'b0; gain_we = 1'b0; gain_addr = '0; gain_data = '0;
    out_ready = 1'b0; ch_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_gain_err", 64'(gain_err), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 9; v++) begin
      if (!vecs[v].all && vecs[v].g != 16'h4000) write_gain(4'(vecs[v].ch), vecs[v].g);
      if (vecs[v].all) begin
        for (int i = 0; i < 16; i++) fr[i] = 33'(vecs[v].x);
      end else begin
        fr = single(vecs[v].ch, vecs[v].x);
      end
      run_frame($sformatf("vec%0d", v), fr, 1'b0, 16'h0, vecs[v].exp_d, vecs[v].exp_s);
      accept($sformatf("vec%0d", v));
      if (!vecs[v].all && vecs[v].g != 16'h4000) write_gain(4'(vecs[v].ch), 16'h4000);
    end

    // Gain written in the capture cycle applies to that frame: 0.25 * 0.5 = 0.125.
    run_frame("capgain", single(0, 64'sd1 <<< 30), 1'b1, 16'h2000, 13'd512, 1'b0);
    check("capgain_err", 64'(gain_err), 64'd0);
    accept("capgain");
    write_gain(4'd0, 16'h4000);

    // Backpressure: drops, rejected gain write, held output.
    run_frame("bp", single(0, 64'sd1 <<< 30), 1'b0, 16'h0, 13'd1024, 1'b0);
    unstable = 0; err_at = 1'b0; err_after = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      in_valid  = (c == 20 || c == 30);
      gain_we   = (c == 10);
      gain_addr = 4'd0;
      gain_data = 16'h1000;
      @(posedge clock); #1;
      if (out_data !== 13'd1024 || out_valid !== 1'b1 || out_sat !== 1'b0) unstable++;
      if (c == 10) err_at = gain_err;
      if (c == 11) err_after = gain_err;
    end
    in_valid = 1'b0; gain_we = 1'b0;
    check("bp_stable_cycles_bad", 64'(unstable), 64'd0);
    check("bp_gain_err_pulse", 64'(err_at), 64'd1);
    check("bp_gain_err_clear", 64'(err_after), 64'd0);
    check("bp_drop_cnt", 64'(drop_cnt), 64'd2);
    accept("bp");
    run_frame("bp_gain_kept", single(0, 64'sd1 <<< 30), 1'b0, 16'h0, 13'd1024, 1'b0);
    accept("bp_gain_kept");

    // Reset during ACCUM aborts the frame and restores unity gains.
    write_gain(4'd0, 16'h2000);
    @(negedge clock);
    ch_in = single(0, 64'sd1 <<< 30); in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_drop_cnt", 64'(drop_cnt), 64'd0);
    run_frame("mrst_next", single(0, 64'sd1 <<< 30), 1'b0, 16'h0, 13'd1024, 1'b0);
    accept("mrst_next");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
